// File: rtl/c7bbiu_lsu_slv.sv
// c7bbiu_lsu_slv: BIU-side responder for the LSU read/write request interface.
// Each accepted LSU request becomes a single transfer on a 64-bit
// req/gnt/response memory port. Only one transaction is outstanding at a time,
// and a watchdog completes a hung transfer with an error pulse.
module c7bbiu_lsu_slv #(
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 16
) (
    input  logic        clk,
    input  logic        resetn,
    // LSU read channel
    input  logic        lsu_biu_rd_req,
    input  logic [31:0] lsu_biu_rd_addr,
    output logic        biu_lsu_rd_ack,
    output logic        biu_lsu_data_valid,
    output logic [63:0] biu_lsu_data,
    // LSU write channel
    input  logic        lsu_biu_wr_req,
    input  logic [31:0] lsu_biu_wr_addr,
    input  logic [63:0] lsu_biu_wr_data,
    input  logic [7:0]  lsu_biu_wr_strb,
    output logic        biu_lsu_wr_ack,
    output logic        biu_lsu_write_done,
    output logic        biu_lsu_err,
    // memory port
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_wstrb,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [63:0] mem_rdata,
    input  logic        mem_wdone
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        WR_REQ  = 3'd3,
        WR_WAIT = 3'd4,
        RESP    = 3'd5
    } state_t;

    // Last watchdog count before the forced completion.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;

    logic start_rd, start_wr;   // request accepted in IDLE
    logic gnt_hit;              // memory accepted the request
    logic rd_done, rd_tmo;      // read finished normally / by watchdog
    logic wr_done, wr_tmo;      // write finished normally / by watchdog

    // Byte-offset bits are dropped: the memory port is doubleword addressed.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{lsu_biu_rd_addr[2:0], lsu_biu_wr_addr[2:0]};

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    // Next-state decode and per-cycle transfer events; write wins over read.
    always_comb begin
        state_nxt = state;
        start_rd  = 1'b0;
        start_wr  = 1'b0;
        gnt_hit   = 1'b0;
        rd_done   = 1'b0;
        rd_tmo    = 1'b0;
        wr_done   = 1'b0;
        wr_tmo    = 1'b0;
        case (state)
            IDLE: begin
                if (lsu_biu_wr_req) begin
                    state_nxt = WR_REQ;
                    start_wr  = 1'b1;
                end else if (lsu_biu_rd_req) begin
                    state_nxt = RD_REQ;
                    start_rd  = 1'b1;
                end
            end
            RD_REQ: begin
                if (mem_gnt) begin
                    state_nxt = RD_WAIT;
                    gnt_hit   = 1'b1;
                end
            end
            WR_REQ: begin
                if (mem_gnt) begin
                    state_nxt = WR_WAIT;
                    gnt_hit   = 1'b1;
                end
            end
            RD_WAIT: begin
                if (mem_rvalid) begin
                    state_nxt = RESP;
                    rd_done   = 1'b1;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = RESP;
                    rd_tmo    = 1'b1;
                end
            end
            WR_WAIT: begin
                if (mem_wdone) begin
                    state_nxt = RESP;
                    wr_done   = 1'b1;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = RESP;
                    wr_tmo    = 1'b1;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The memory request is a pure function of state, so it drops the cycle after grant.
    assign mem_req = (state == RD_REQ) || (state == WR_REQ);
    assign mem_we  = (state == WR_REQ);

    // Watchdog: restarts on grant, counts every cycle spent waiting for the response.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            cnt <= '0;
        else if (gnt_hit)
            cnt <= '0;
        else if (state == RD_WAIT || state == WR_WAIT)
            cnt <= cnt + 1'b1;
    end

    // Registered LSU pulses; completion pulses and err are high during RESP.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            biu_lsu_rd_ack     <= 1'b0;
            biu_lsu_wr_ack     <= 1'b0;
            biu_lsu_data_valid <= 1'b0;
            biu_lsu_write_done <= 1'b0;
            biu_lsu_err        <= 1'b0;
        end else begin
            biu_lsu_rd_ack     <= start_rd;
            biu_lsu_wr_ack     <= start_wr;
            biu_lsu_data_valid <= rd_done | rd_tmo;
            biu_lsu_write_done <= wr_done | wr_tmo;
            biu_lsu_err        <= rd_tmo | wr_tmo;
        end
    end

    // Transfer payload: captured on accept, held until the next accept.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
        end else if (start_wr) begin
            mem_addr  <= {lsu_biu_wr_addr[31:3], 3'b000};
            mem_wdata <= lsu_biu_wr_data;
            mem_wstrb <= lsu_biu_wr_strb;
        end else if (start_rd) begin
            mem_addr  <= {lsu_biu_rd_addr[31:3], 3'b000};
        end
    end

    // Read data holds until the next read completion; a timed-out read returns zero.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)      biu_lsu_data <= '0;
        else if (rd_done) biu_lsu_data <= mem_rdata;
        else if (rd_tmo)  biu_lsu_data <= '0;
    end

endmodule

// File: tb/tb_c7bbiu_lsu_slv.sv
// Directed bench for c7bbiu_lsu_slv with a completion scoreboard.
module tb_c7bbiu_lsu_slv;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        rd_req = 1'b0;
    logic [31:0] rd_addr = '0;
    logic        rd_ack, dv, wr_ack, wd, err;
    logic [63:0] rdat;
    logic        wr_req = 1'b0;
    logic [31:0] wr_addr = '0;
    logic [63:0] wr_data = '0;
    logic [7:0]  wr_strb = '0;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wstrb;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [63:0] mem_rdata = '0;
    logic        mem_wdone = 1'b0;

    c7bbiu_lsu_slv #(.TIMEOUT(TMO), .CNT_W(16)) dut (
        .clk(clk), .resetn(resetn),
        .lsu_biu_rd_req(rd_req), .lsu_biu_rd_addr(rd_addr),
        .biu_lsu_rd_ack(rd_ack), .biu_lsu_data_valid(dv), .biu_lsu_data(rdat),
        .lsu_biu_wr_req(wr_req), .lsu_biu_wr_addr(wr_addr),
        .lsu_biu_wr_data(wr_data), .lsu_biu_wr_strb(wr_strb),
        .biu_lsu_wr_ack(wr_ack), .biu_lsu_write_done(wd), .biu_lsu_err(err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .mem_wdone(mem_wdone)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_wr;
        logic        err;
        logic [63:0] data;
    } exp_t;

    exp_t sbq[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   n_rd_ack = 0, n_wr_ack = 0, n_dv = 0, n_wd = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic is_wr, input logic e, input logic [63:0] d);
        exp_t x;
        x.is_wr = is_wr;
        x.err   = e;
        x.data  = d;
        sbq.push_back(x);
    endtask

    // Advance one cycle, sample 1 time unit after the edge, score completions.
    task automatic tick();
        exp_t x;
        @(posedge clk);
        #1;
        n_rd_ack += int'(rd_ack);
        n_wr_ack += int'(wr_ack);
        n_dv     += int'(dv);
        n_wd     += int'(wd);
        if (err && !(dv || wd)) check("err_without_completion", 64'(err), 64'd0);
        if (dv || wd) begin
            if (sbq.size() == 0) begin
                check("sb_unexpected_completion", 64'(dv | wd), 64'd0);
            end else begin
                x = sbq.pop_front();
                check("sb_kind_is_wr", 64'(wd), 64'(x.is_wr));
                check("sb_err", 64'(err), 64'(x.err));
                if (!x.is_wr) check("sb_rdata", rdat, x.data);
            end
        end
    endtask

    task automatic chk_all_zero(input string tag);
        check({tag, "_ctl"}, 64'({rd_ack, dv, wr_ack, wd, err, mem_req, mem_we, mem_wstrb, mem_addr}), 64'd0);
        check({tag, "_rdata"}, rdat, 64'd0);
        check({tag, "_wdata"}, mem_wdata, 64'd0);
    endtask

    // Zero-wait read: grant in first RD_REQ cycle, rvalid in first RD_WAIT cycle.
    task automatic rd_zero_wait(input string tag, input logic [31:0] a, input logic [63:0] d);
        rd_req = 1'b1; rd_addr = a; mem_gnt = 1'b1;
        push(1'b0, 1'b0, d);
        tick();
        check({tag, "_ack"}, 64'(rd_ack), 64'd1);
        check({tag, "_mem_req"}, 64'({mem_req, mem_we}), 64'b10);
        check({tag, "_mem_addr"}, 64'(mem_addr), 64'({a[31:3], 3'b000}));
        rd_req = 1'b0;
        tick();
        check({tag, "_ack_once"}, 64'({rd_ack, mem_req, dv}), 64'd0);
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = d;
        tick();
        check({tag, "_dv_t3"}, 64'({dv, err}), 64'b10);
        mem_rvalid = 1'b0; mem_rdata = '0;
        tick();
        check({tag, "_dv_once"}, 64'(dv), 64'd0);
        check({tag, "_data_hold"}, rdat, d);
    endtask

    initial begin
        // ---- reset state ----
        #2;
        chk_all_zero("reset");
        tick();
        tick();
        chk_all_zero("reset_held");
        resetn = 1'b1;
        tick();

        // ---- zero-wait read ----
        n_rd_ack = 0; n_dv = 0;
        rd_zero_wait("rd0", 32'h1000_000C, 64'h1122_3344_5566_7788);
        check("rd0_ack_count", 64'(n_rd_ack), 64'd1);
        check("rd0_dv_count", 64'(n_dv), 64'd1);

        // ---- write with stalls ----
        n_wr_ack = 0; n_wd = 0;
        wr_req = 1'b1; wr_addr = 32'h2000_0004; wr_data = 64'hDEAD_BEEF_CAFE_F00D; wr_strb = 8'hF0;
        push(1'b1, 1'b0, '0);
        tick();
        check("wr_ack", 64'(wr_ack), 64'd1);
        check("wr_mem_addr", 64'(mem_addr), 64'h2000_0000);
        check("wr_mem_wdata", mem_wdata, 64'hDEAD_BEEF_CAFE_F00D);
        wr_req = 1'b0; wr_data = '0; wr_strb = '0;
        for (int i = 0; i < 3; i++) begin
            check("wr_req_held", 64'({mem_req, mem_we, mem_wstrb}), 64'({2'b11, 8'hF0}));
            if (i == 2) mem_gnt = 1'b1;
            tick();
        end
        mem_gnt = 1'b0;
        check("wr_req_dropped", 64'(mem_req), 64'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("wr_no_early_done", 64'(wd), 64'd0);
        end
        mem_wdone = 1'b1;
        tick();
        check("wr_done_pulse", 64'(wd), 64'd1);
        mem_wdone = 1'b0;
        tick();
        check("wr_done_once", 64'(wd), 64'd0);
        check("wr_ack_count", 64'(n_wr_ack), 64'd1);

        // ---- simultaneous read and write: write first ----
        n_rd_ack = 0; n_wr_ack = 0; n_dv = 0; n_wd = 0;
        rd_req = 1'b1; rd_addr = 32'h3000_0010;
        wr_req = 1'b1; wr_addr = 32'h3000_0020; wr_data = 64'h0123_4567_89AB_CDEF; wr_strb = 8'hFF;
        mem_gnt = 1'b1;
        push(1'b1, 1'b0, '0);
        push(1'b0, 1'b0, 64'hA5A5_0000_5A5A_FFFF);
        tick();
        check("sim_wr_first", 64'({wr_ack, rd_ack, mem_we}), 64'b101);
        check("sim_wr_addr", 64'(mem_addr), 64'h3000_0020);
        wr_req = 1'b0;
        tick();
        mem_wdone = 1'b1;
        tick();
        check("sim_wr_done", 64'(wd), 64'd1);
        mem_wdone = 1'b0;
        tick();
        tick();
        check("sim_rd_ack", 64'({rd_ack, wr_ack, mem_we}), 64'b100);
        check("sim_rd_addr", 64'(mem_addr), 64'h3000_0010);
        rd_req = 1'b0;
        tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'hA5A5_0000_5A5A_FFFF;
        tick();
        mem_rvalid = 1'b0;
        tick();
        tick();
        check("sim_counts", 64'({8'(n_wr_ack), 8'(n_wd), 8'(n_rd_ack), 8'(n_dv)}),
              64'({8'd1, 8'd1, 8'd1, 8'd1}));

        // ---- watchdog timeout on read ----
        rd_req = 1'b1; rd_addr = 32'h4000_0008; mem_gnt = 1'b1;
        push(1'b0, 1'b1, 64'd0);
        tick();
        check("tmo_ack", 64'(rd_ack), 64'd1);
        rd_req = 1'b0;
        for (int i = 0; i < TMO; i++) begin
            tick();
            mem_gnt = 1'b0;
            check("tmo_no_early_dv", 64'({dv, err}), 64'd0);
        end
        tick();
        check("tmo_dv_err", 64'({dv, err}), 64'b11);
        check("tmo_data_zero", rdat, 64'd0);
        tick();
        check("tmo_err_once", 64'({dv, err}), 64'd0);
        rd_zero_wait("after_tmo", 32'h4000_0010, 64'h0F0F_1234_5678_F0F0);

        // ---- reset in RD_WAIT ----
        rd_req = 1'b1; rd_addr = 32'h5000_0000; mem_gnt = 1'b1;
        tick();
        rd_req = 1'b0;
        tick();
        mem_gnt = 1'b0;
        #2 resetn = 1'b0;
        #1;
        chk_all_zero("rst_mid");
        tick();
        resetn = 1'b1;
        tick();
        n_dv = 0;
        mem_rvalid = 1'b1; mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
        tick();
        tick();
        mem_rvalid = 1'b0; mem_rdata = '0;
        tick();
        check("rst_late_rvalid_ignored", 64'(n_dv), 64'd0);
        rd_zero_wait("after_rst", 32'h5000_0018, 64'h7777_8888_9999_AAAA);

        // ---- back-to-back reads, req held high ----
        n_rd_ack = 0;
        rd_req = 1'b1; rd_addr = 32'h6000_0000; mem_gnt = 1'b1; mem_rvalid = 1'b1;
        mem_rdata = 64'hCCCC_DDDD_EEEE_FFFF;
        for (int i = 0; i < 3; i++) push(1'b0, 1'b0, 64'hCCCC_DDDD_EEEE_FFFF);
        for (int i = 1; i <= 12; i++) begin
            tick();
            check("b2b_ack", 64'(rd_ack), 64'(i % 4 == 1));
            check("b2b_dv", 64'(dv), 64'(i % 4 == 3));
            if (i == 9) rd_req = 1'b0;
        end
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        check("b2b_ack_count", 64'(n_rd_ack), 64'd3);
        check("sb_drained", 64'(sbq.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
